// File: rtl/hist_equalize.sv
// Histogram equalisation: builds the CDF from 256 histogram bins, derives an
// 8-bit remap LUT by restoring division, then rewrites the frame store through it.
module hist_equalize #(
  parameter int V_SIZE = 64,
  parameter int H_SIZE = 64,
  parameter int ADDR_W = 12,
  parameter int CNT_W  = 13
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              hist_rd,
  output logic [7:0]        hist_addr,
  input  logic              hist_val,
  input  logic [CNT_W-1:0]  hist_data,
  output logic              rd_pixel,
  output logic [ADDR_W-1:0] addr_pixel,
  input  logic              pixel_val,
  input  logic [23:0]       pixel_in,
  output logic              wr_pixel,
  output logic [23:0]       pixel_out,
  output logic              busy,
  output logic              done,
  output logic              hist_err
);

  localparam int N     = V_SIZE * H_SIZE;
  localparam int DIV_W = CNT_W + 8;
  localparam int DC_W  = $clog2(DIV_W);
  localparam logic [CNT_W-1:0]  N_C    = CNT_W'(N);
  localparam logic [ADDR_W-1:0] LAST_A = ADDR_W'(N - 1);

  typedef enum logic [2:0] {
    IDLE, H_REQ, H_WAIT, H_DIV, P_REQ, P_WAIT, P_WR, DONE
  } state_t;

  state_t            state_q, state_d;
  logic [7:0]        bin_q, bin_d;
  logic [CNT_W-1:0]  acc_q, acc_d;
  logic              sat_q, sat_d;
  logic [CNT_W-1:0]  cdf_min_q, cdf_min_d;
  logic              degen_q, degen_d;
  logic [DIV_W-1:0]  div_q, div_d;
  logic [CNT_W-1:0]  rem_q, rem_d;
  logic [DC_W-1:0]   div_cnt_q, div_cnt_d;
  logic              hist_rd_q, hist_rd_d;
  logic [7:0]        hist_addr_q, hist_addr_d;
  logic              rd_pixel_q, rd_pixel_d;
  logic [ADDR_W-1:0] addr_pixel_q, addr_pixel_d;
  logic              wr_pixel_q, wr_pixel_d;
  logic [23:0]       pixel_out_q, pixel_out_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              hist_err_q, hist_err_d;

  logic [7:0]        lut_q [256];
  logic              lut_we;
  logic [7:0]        lut_wd;

  logic [CNT_W:0]    sum;
  logic [CNT_W-1:0]  diff;
  logic [CNT_W-1:0]  divisor;
  logic [CNT_W:0]    rem_shift;
  logic              qbit;
  logic [DIV_W-1:0]  quot_next;
  logic [7:0]        gray;
  logic [7:0]        remap;
  logic              bin_done;
  logic              unused_ok;

  assign unused_ok = ^pixel_in[15:0];

  always_comb begin
    state_d      = state_q;
    bin_d        = bin_q;
    acc_d        = acc_q;
    sat_d        = sat_q;
    cdf_min_d    = cdf_min_q;
    degen_d      = degen_q;
    div_d        = div_q;
    rem_d        = rem_q;
    div_cnt_d    = div_cnt_q;
    hist_rd_d    = 1'b0;
    hist_addr_d  = hist_addr_q;
    rd_pixel_d   = 1'b0;
    addr_pixel_d = addr_pixel_q;
    wr_pixel_d   = 1'b0;
    pixel_out_d  = pixel_out_q;
    done_d       = done_q;
    hist_err_d   = hist_err_q;
    lut_we       = 1'b0;
    lut_wd       = '0;
    sum          = '0;
    diff         = '0;
    divisor      = N_C - cdf_min_q;
    rem_shift    = {rem_q, div_q[DIV_W-1]};
    qbit         = (rem_shift >= {1'b0, divisor});
    quot_next    = {div_q[DIV_W-2:0], qbit};
    gray         = pixel_in[23:16];
    remap        = degen_q ? gray : lut_q[gray];
    bin_done     = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          done_d      = 1'b0;
          hist_err_d  = 1'b0;
          acc_d       = '0;
          sat_d       = 1'b0;
          cdf_min_d   = '0;
          degen_d     = 1'b0;
          bin_d       = '0;
          hist_addr_d = '0;
          hist_rd_d   = 1'b1;
          state_d     = H_REQ;
        end
      end
      H_REQ: state_d = H_WAIT;
      H_WAIT: begin
        if (hist_val) begin
          sum = {1'b0, acc_q} + {1'b0, hist_data};
          if (sum[CNT_W]) begin
            acc_d = '1;
            sat_d = 1'b1;
          end else begin
            acc_d = sum[CNT_W-1:0];
          end
          if (cdf_min_q == '0 && hist_data != '0) cdf_min_d = hist_data;
          // dividend = (acc - cdf_min) * 255, formed as x*256 - x
          diff      = acc_d - cdf_min_d;
          div_d     = {diff, 8'h00} - DIV_W'(diff);
          rem_d     = '0;
          div_cnt_d = '0;
          state_d   = H_DIV;
        end
      end
      H_DIV: begin
        if (acc_q == '0) begin
          lut_we   = 1'b1;
          bin_done = 1'b1;
        end else if (divisor == '0) begin
          degen_d  = 1'b1;
          bin_done = 1'b1;
        end else begin
          rem_d     = qbit ? CNT_W'(rem_shift - {1'b0, divisor}) : rem_shift[CNT_W-1:0];
          div_d     = quot_next;
          div_cnt_d = div_cnt_q + 1'b1;
          if (div_cnt_q == DC_W'(DIV_W - 1)) begin
            lut_we   = 1'b1;
            lut_wd   = quot_next[7:0];
            bin_done = 1'b1;
          end
        end
      end
      P_REQ: state_d = P_WAIT;
      P_WAIT: begin
        if (pixel_val) begin
          pixel_out_d = {remap, remap, remap};
          wr_pixel_d  = 1'b1;
          state_d     = P_WR;
        end
      end
      P_WR: begin
        if (addr_pixel_q == LAST_A) begin
          addr_pixel_d = '0;
          done_d       = 1'b1;
          state_d      = DONE;
        end else begin
          addr_pixel_d = addr_pixel_q + 1'b1;
          rd_pixel_d   = 1'b1;
          state_d      = P_REQ;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (bin_done) begin
      if (bin_q == 8'hFF) begin
        hist_err_d   = sat_q || (acc_q != N_C);
        addr_pixel_d = '0;
        rd_pixel_d   = 1'b1;
        state_d      = P_REQ;
      end else begin
        bin_d       = bin_q + 1'b1;
        hist_addr_d = bin_q + 1'b1;
        hist_rd_d   = 1'b1;
        state_d     = H_REQ;
      end
    end

    busy_d = !(state_d == IDLE || state_d == DONE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      bin_q        <= '0;
      acc_q        <= '0;
      sat_q        <= 1'b0;
      cdf_min_q    <= '0;
      degen_q      <= 1'b0;
      div_q        <= '0;
      rem_q        <= '0;
      div_cnt_q    <= '0;
      hist_rd_q    <= 1'b0;
      hist_addr_q  <= '0;
      rd_pixel_q   <= 1'b0;
      addr_pixel_q <= '0;
      wr_pixel_q   <= 1'b0;
      pixel_out_q  <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      hist_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      bin_q        <= bin_d;
      acc_q        <= acc_d;
      sat_q        <= sat_d;
      cdf_min_q    <= cdf_min_d;
      degen_q      <= degen_d;
      div_q        <= div_d;
      rem_q        <= rem_d;
      div_cnt_q    <= div_cnt_d;
      hist_rd_q    <= hist_rd_d;
      hist_addr_q  <= hist_addr_d;
      rd_pixel_q   <= rd_pixel_d;
      addr_pixel_q <= addr_pixel_d;
      wr_pixel_q   <= wr_pixel_d;
      pixel_out_q  <= pixel_out_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      hist_err_q   <= hist_err_d;
    end
  end

  // LUT contents need no reset: every entry is rewritten before remap reads it
  always_ff @(posedge clk) begin
    if (lut_we) lut_q[bin_q] <= lut_wd;
  end

  assign hist_rd    = hist_rd_q;
  assign hist_addr  = hist_addr_q;
  assign rd_pixel   = rd_pixel_q;
  assign addr_pixel = addr_pixel_q;
  assign wr_pixel   = wr_pixel_q;
  assign pixel_out  = pixel_out_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign hist_err   = hist_err_q;

endmodule
